// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-port round-robin sequencer for the single-port data memory.
// Define MEM_ARB_FIXED_PRIO_EN to make port 0 always win contention instead.
module mem_arb #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_in,
  input  logic          we0_in,
  input  logic [AW-1:0] addr0_in,
  input  logic [DW-1:0] wdata0_in,
  output logic          gnt0_out,
  output logic          rvalid0_out,
  output logic [DW-1:0] rdata0_out,
  input  logic          req1_in,
  input  logic          we1_in,
  input  logic [AW-1:0] addr1_in,
  input  logic [DW-1:0] wdata1_in,
  output logic          gnt1_out,
  output logic          rvalid1_out,
  output logic [DW-1:0] rdata1_out,
  output logic          mem_en_out,
  output logic          mem_we_out,
  output logic [AW-1:0] mem_addr_out,
  output logic [DW-1:0] mem_wdata_out,
  input  logic [DW-1:0] mem_rdata_in
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACC   = 2'd1;
  localparam logic [1:0] S_RWAIT = 2'd2;
  localparam logic [1:0] S_RRET  = 2'd3;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  logic [1:0] state;
  logic       lp;
  logic       sel;
  logic [2:0] cnt;
  logic       pick;

  always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    pick = ~req0_in;
`else
    // Contention goes to the port that was not served last.
    pick = (req0_in && req1_in) ? ~lp : req1_in;
`endif
  end

  // The memory pins double as the latched request; they are only loaded on selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      lp            <= 1'b1;
      sel           <= 1'b0;
      cnt           <= 3'd0;
      gnt0_out      <= 1'b0;
      gnt1_out      <= 1'b0;
      rvalid0_out   <= 1'b0;
      rvalid1_out   <= 1'b0;
      rdata0_out    <= '0;
      rdata1_out    <= '0;
      mem_en_out    <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
    end else begin
      gnt0_out    <= 1'b0;
      gnt1_out    <= 1'b0;
      rvalid0_out <= 1'b0;
      rvalid1_out <= 1'b0;
      mem_en_out  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0_in || req1_in) begin
            sel           <= pick;
            mem_we_out    <= pick ? we1_in    : we0_in;
            mem_addr_out  <= pick ? addr1_in  : addr0_in;
            mem_wdata_out <= pick ? wdata1_in : wdata0_in;
            mem_en_out    <= 1'b1;
            gnt0_out      <= ~pick;
            gnt1_out      <= pick;
            state         <= S_ACC;
          end
        end
        S_ACC: begin
          lp <= sel;
          if (mem_we_out) begin
            state <= S_IDLE;
          end else begin
            cnt   <= LAT_M1;
            state <= (MEM_LAT == 1) ? S_RRET : S_RWAIT;
          end
        end
        S_RWAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= S_RRET;
          end
        end
        S_RRET: begin
          if (sel) begin
            rvalid1_out <= 1'b1;
            rdata1_out  <= mem_rdata_in;
          end else begin
            rvalid0_out <= 1'b1;
            rdata0_out  <= mem_rdata_in;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - scoreboard bench for mem_arb with a latency-accurate memory model.
module tb_mem_arb;

  localparam int LAT = 2;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct packed { logic we; logic [15:0] addr; logic [15:0] wdata; } req_t;
  typedef struct packed { logic [15:0] data; int due; } rd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic gnt0_out, rvalid0_out, gnt1_out, rvalid1_out, mem_en_out, mem_we_out;
  logic [15:0] rdata0_out, rdata1_out, mem_addr_out, mem_wdata_out, mem_rdata_in;

  logic [15:0] mem [256] = '{default: '0};
  logic [15:0] ref_mem [256] = '{default: '0};
  logic [15:0] pipe [LAT];

  req_t eq0[$], eq1[$];
  rd_t  rq0[$], rq1[$];
  int   gorder[$];
  int   n_cmp = 0, n_err = 0, cyc = 0, lat;
  logic last_g = 1'b1, prv0 = 1'b0, prv1 = 1'b0;
  logic any_out;

  assign any_out = |{gnt0_out, rvalid0_out, rdata0_out, gnt1_out, rvalid1_out, rdata1_out,
                     mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out};
  assign mem_rdata_in = pipe[LAT-1];

  mem_arb #(.AW(16), .DW(16), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_in(req0), .we0_in(we0), .addr0_in(addr0), .wdata0_in(wdata0),
    .gnt0_out(gnt0_out), .rvalid0_out(rvalid0_out), .rdata0_out(rdata0_out),
    .req1_in(req1), .we1_in(we1), .addr1_in(addr1), .wdata1_in(wdata1),
    .gnt1_out(gnt1_out), .rvalid1_out(rvalid1_out), .rdata1_out(rdata1_out),
    .mem_en_out(mem_en_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
    .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in)
  );

  initial forever #5 clk = ~clk;

  // Memory: data for an access strobed in cycle t is presented in cycle t+LAT.
  always @(posedge clk) begin
    if (mem_en_out && mem_we_out) mem[mem_addr_out[7:0]] <= mem_wdata_out;
    pipe[0] <= mem[mem_addr_out[7:0]];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    req_t e;
    rd_t  r;
    int   p, w;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("rst_out", {31'd0, any_out}, 0);
        rq0.delete(); rq1.delete();
        last_g = 1'b1; prv0 = 1'b0; prv1 = 1'b0;
      end else begin
        if (gnt0_out || gnt1_out || mem_en_out) begin
          p = gnt1_out ? 1 : 0;
          chk("gnt_en", {29'd0, gnt0_out, gnt1_out, mem_en_out}, p == 1 ? 3'b011 : 3'b101);
          if (prv0 && prv1) w = FIXED ? 0 : (last_g ? 0 : 1);
          else w = prv1 ? 1 : 0;
          chk("arb_winner", p, w);
          chk("arb_req", {31'd0, p == 1 ? prv1 : prv0}, 1);
          last_g = (p == 1);
          gorder.push_back(p);
          chk("gnt_pending", {31'd0, (p == 1 ? eq1.size() : eq0.size()) > 0}, 1);
          if ((p == 1 ? eq1.size() : eq0.size()) > 0) begin
            e = (p == 1) ? eq1.pop_front() : eq0.pop_front();
            chk("mem_we", {31'd0, mem_we_out}, {31'd0, e.we});
            chk("mem_addr", mem_addr_out, e.addr);
            if (e.we) begin
              chk("mem_wdata", mem_wdata_out, e.wdata);
              ref_mem[e.addr[7:0]] = e.wdata;
            end else begin
              r.data = ref_mem[e.addr[7:0]];
              r.due  = cyc + LAT + 1;
              if (p == 1) rq1.push_back(r); else rq0.push_back(r);
            end
          end
        end
        if (rvalid0_out) begin
          chk("rv0_expected", {31'd0, rq0.size() > 0}, 1);
          if (rq0.size() > 0) begin
            r = rq0.pop_front();
            chk("rdata0", rdata0_out, r.data);
            chk("rv0_latency", cyc, r.due);
          end
        end
        if (rvalid1_out) begin
          chk("rv1_expected", {31'd0, rq1.size() > 0}, 1);
          if (rq1.size() > 0) begin
            r = rq1.pop_front();
            chk("rdata1", rdata1_out, r.data);
            chk("rv1_latency", cyc, r.due);
          end
        end
        prv0 = req0;
        prv1 = req1;
      end
    end
  endtask

  task automatic access(input int p, input logic w, input logic [15:0] a,
                        input logic [15:0] d, output int l);
    req_t e;
    e = '{we: w, addr: a, wdata: d};
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; eq0.push_back(e); end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; eq1.push_back(e); end
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!(p == 0 ? gnt0_out : gnt1_out) && l < 300);
    chk("gnt_seen", {31'd0, p == 0 ? gnt0_out : gnt1_out}, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drop(input int p);
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    fork monitor(); join_none
    idle(3);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("idle_out", {31'd0, any_out}, 0);
    end
    @(posedge clk); #1;

    access(0, 1'b1, 16'h0010, 16'hBEEF, lat);
    chk("wr_lat", lat, 2);
    drop(0);
    idle(3);
    access(1, 1'b0, 16'h0010, 16'h0000, lat);
    drop(1);
    idle(6);

    gorder.delete();
    fork
      begin for (int i = 0; i < 8; i++) access(0, 1'b0, 16'($urandom_range(0, 15)), 16'h0, lat); drop(0); end
      begin for (int i = 0; i < 8; i++) access(1, 1'b0, 16'($urandom_range(0, 15)), 16'h0, lat); drop(1); end
    join
    idle(8);
    chk("rr_count", {31'd0, gorder.size() >= 8}, 1);
    for (int i = 0; i < 8 && i < gorder.size(); i++)
      chk("rr_order", gorder[i], FIXED ? 0 : i % 2);

    access(0, 1'b0, 16'h0010, 16'h0, lat);
    drop(0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    gorder.delete();
    fork
      begin access(0, 1'b0, 16'h0003, 16'h0, lat); drop(0); end
      begin access(1, 1'b0, 16'h0004, 16'h0, lat); drop(1); end
    join
    idle(8);
    chk("rst_first", gorder.size() > 0 ? gorder[0] : 9, 0);

    access(0, 1'b0, 16'h0005, 16'h0, lat);
    drop(0);
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0006; wdata1 = 16'h1234;
    idle(2);
    req1 = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("drop_idle", {30'd0, mem_en_out, gnt1_out}, 0);
    end
    @(posedge clk); #1;

    fork
      begin
        for (int i = 0; i < 20; i++) begin
          access(0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 16'($urandom), lat);
          if ($urandom_range(0, 1) == 1) begin drop(0); idle($urandom_range(1, 3)); end
        end
        drop(0);
      end
      begin
        for (int i = 0; i < 20; i++) begin
          access(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 16'($urandom), lat);
          if ($urandom_range(0, 1) == 1) begin drop(1); idle($urandom_range(1, 3)); end
        end
        drop(1);
      end
    join
    idle(10);
    chk("drain_req", eq0.size() + eq1.size(), 0);
    chk("drain_rd", rq0.size() + rq1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
